// File: rtl/reg_snapshot_ctrl_if.sv
// write_back_ifc: same-cycle write-back bus from the write-back stage.
//   uses_rw  1           write-back valid this cycle
//   rw_addr  5           destination architectural register
//   rw_data  DATA_WIDTH  value being written
// Modports: master (write-back stage drives), slave / in (consumers sample).
interface write_back_ifc #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  uses_rw;
    logic [4:0]            rw_addr;
    logic [DATA_WIDTH-1:0] rw_data;

    modport master (output uses_rw, output rw_addr, output rw_data);
    modport slave  (input  uses_rw, input  rw_addr, input  rw_data);
    modport in     (input  uses_rw, input  rw_addr, input  rw_data);
endinterface

// File: rtl/reg_snapshot_ctrl.sv
// reg_snapshot_ctrl: checkpoint queue beside reg_file. Captures the register
// image on each predicted branch, retires the oldest on a correct resolve and
// runs the REQ/WAIT/ACK restore handshake on a mispredict.
// Optional feature macro: SNAPSHOT_WB_BYPASS_EN (merge same-cycle write-back
// into the captured image).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   checkpoint_req      capture request from decode
//   checkpoint_full     queue full or recovery active (combinational)
//   regs_out            live register contents
//   i_wb                same-cycle write-back bus
//   resolve_valid       oldest branch resolved
//   resolve_mispredict  qualifies resolve_valid
//   regs_snapshot       oldest slot contents (combinational)
//   recover_snapshot    one-cycle restore command
//   done                restore-complete pulse from reg_file
//   recovery_done_ack   one-cycle acknowledge
//   recovering          FSM not in IDLE
module reg_snapshot_ctrl #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        checkpoint_req,
    output logic                        checkpoint_full,
    input  logic [31:0][DATA_WIDTH-1:0] regs_out,
    write_back_ifc.in                   i_wb,
    input  logic                        resolve_valid,
    input  logic                        resolve_mispredict,
    output logic [31:0][DATA_WIDTH-1:0] regs_snapshot,
    output logic                        recover_snapshot,
    input  logic                        done,
    output logic                        recovery_done_ack,
    output logic                        recovering
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        ACK  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               recover_q, recover_d;
    logic               ack_q, ack_d;
    logic               recovering_q, recovering_d;

    logic [31:0][DATA_WIDTH-1:0] slot_q [DEPTH];
    logic [31:0][DATA_WIDTH-1:0] image_c;

    logic push_c, pop_c, misp_c, full_c, nonempty_c;

    // Image to capture: raw register file, optionally with the write-back merged in
    always_comb begin
        image_c = regs_out;
`ifdef SNAPSHOT_WB_BYPASS_EN
        if (i_wb.uses_rw) begin
            image_c[i_wb.rw_addr] = DATA_WIDTH'(i_wb.rw_data);
        end
`endif
    end

`ifndef SNAPSHOT_WB_BYPASS_EN
    // Write-back bus is intentionally excluded from the snapshot in this build
    logic wb_unused_c;
    assign wb_unused_c = ^{i_wb.uses_rw, i_wb.rw_addr, i_wb.rw_data};
`endif

    assign full_c     = (count_q == CNT_W'(DEPTH));
    assign nonempty_c = (count_q != '0);

    // Queue events; only meaningful while IDLE (gated in the FSM)
    assign misp_c = resolve_valid & resolve_mispredict & nonempty_c;
    assign pop_c  = resolve_valid & ~resolve_mispredict & nonempty_c;

    // Next-state, pointer and output logic
    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        push_c       = 1'b0;
        recover_d    = 1'b0;
        ack_d        = 1'b0;
        recovering_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (misp_c) begin
                    // Any same-cycle request is younger than the bad branch: drop it
                    state_d = REQ;
                end else begin
                    // A simultaneous pop frees a slot, so pushing when full is legal
                    push_c = checkpoint_req & (~full_c | pop_c);
                    if (pop_c) begin
                        head_d = head_q + PTR_W'(1);
                    end
                    if (push_c) begin
                        tail_d = tail_q + PTR_W'(1);
                    end
                    case ({push_c, pop_c})
                        2'b10:   count_d = count_q + CNT_W'(1);
                        2'b01:   count_d = count_q - CNT_W'(1);
                        default: count_d = count_q;
                    endcase
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (done) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, decoded from the upcoming state
        recover_d    = (state_d == REQ);
        ack_d        = (state_d == ACK);
        recovering_d = (state_d != IDLE);
    end

    // State and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            recover_q    <= 1'b0;
            ack_q        <= 1'b0;
            recovering_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            recover_q    <= recover_d;
            ack_q        <= ack_d;
            recovering_q <= recovering_d;
        end
    end

    // Slot storage, not reset
    always_ff @(posedge clk) begin
        if (push_c && !rst) begin
            slot_q[tail_q] <= image_c;
        end
    end

    assign regs_snapshot     = slot_q[head_q];
    assign checkpoint_full   = full_c | (state_q != IDLE);
    assign recover_snapshot  = recover_q;
    assign recovery_done_ack = ack_q;
    assign recovering        = recovering_q;

endmodule

// File: tb/tb_reg_snapshot_ctrl.sv
// Directed bench for reg_snapshot_ctrl with DEPTH=4, DATA_WIDTH=32.
module tb_reg_snapshot_ctrl;
    logic               clk = 1'b0;
    logic               rst;
    logic               checkpoint_req;
    logic               checkpoint_full;
    logic [31:0][31:0]  regs;
    logic               resolve_valid;
    logic               resolve_mispredict;
    logic [31:0][31:0]  regs_snapshot;
    logic               recover_snapshot;
    logic               done;
    logic               recovery_done_ack;
    logic               recovering;

    int n_total = 0;
    int n_bad   = 0;
    int rs_cnt  = 0;
    int ack_cnt = 0;

    write_back_ifc #(.DATA_WIDTH(32)) wb_if ();

    reg_snapshot_ctrl #(.DEPTH(4), .DATA_WIDTH(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .checkpoint_req     (checkpoint_req),
        .checkpoint_full    (checkpoint_full),
        .regs_out           (regs),
        .i_wb               (wb_if.in),
        .resolve_valid      (resolve_valid),
        .resolve_mispredict (resolve_mispredict),
        .regs_snapshot      (regs_snapshot),
        .recover_snapshot   (recover_snapshot),
        .done               (done),
        .recovery_done_ack  (recovery_done_ack),
        .recovering         (recovering)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (recover_snapshot)  rs_cnt  = rs_cnt + 1;
        if (recovery_done_ack) ack_cnt = ack_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_r7;

        rst = 1'b1;
        checkpoint_req = 1'b0;
        resolve_valid = 1'b0;
        resolve_mispredict = 1'b0;
        done = 1'b0;
        regs = '0;
        wb_if.uses_rw = 1'b0;
        wb_if.rw_addr = '0;
        wb_if.rw_data = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_recovering", recovering, 0);
        chk("rst_recover", recover_snapshot, 0);
        chk("rst_ack", recovery_done_ack, 0);
        chk("rst_full", checkpoint_full, 0);
        chk("rst_count", dut.count_q, 0);

        // Push then correct resolve
        regs[5] = 32'h11;
        checkpoint_req = 1'b1;
        tick();
        checkpoint_req = 1'b0;
        chk("t1_count_push", dut.count_q, 1);
        resolve_valid = 1'b1;
        tick();
        resolve_valid = 1'b0;
        chk("t1_count_pop", dut.count_q, 0);
        chk("t1_head", dut.head_q, 1);
        tick();
        chk("t1_no_recover", rs_cnt, 0);

        // Push R5=0x11, write-back R5=0x22, then mispredict
        checkpoint_req = 1'b1;
        tick();
        checkpoint_req = 1'b0;
        wb_if.uses_rw = 1'b1;
        wb_if.rw_addr = 5'd5;
        wb_if.rw_data = 32'h22;
        tick();
        wb_if.uses_rw = 1'b0;
        regs[5] = 32'h22;
        resolve_valid = 1'b1;
        resolve_mispredict = 1'b1;
        tick();
        resolve_valid = 1'b0;
        resolve_mispredict = 1'b0;
        chk("t2_recover_hi", recover_snapshot, 1);
        chk("t2_snap_r5", regs_snapshot[5], 32'h11);
        chk("t2_full_busy", checkpoint_full, 1);
        tick();
        chk("t2_recover_lo", recover_snapshot, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t2_ack_hi", recovery_done_ack, 1);
        tick();
        chk("t2_ack_lo", recovery_done_ack, 0);
        chk("t2_idle", recovering, 0);
        chk("t2_count", dut.count_q, 0);
        chk("t2_rs_pulses", rs_cnt, 1);
        chk("t2_ack_pulses", ack_cnt, 1);

        // Fill, overflow drop, push+pop while full
        for (int i = 0; i < 4; i++) begin
            regs[0] = 32'(i);
            checkpoint_req = 1'b1;
            tick();
        end
        chk("t3_full", checkpoint_full, 1);
        chk("t3_count4", dut.count_q, 4);
        regs[0] = 32'h99;
        tick();
        chk("t3_drop_count", dut.count_q, 4);
        chk("t3_drop_tail", dut.tail_q, 0);
        chk("t3_drop_slot", regs_snapshot[0], 0);
        resolve_valid = 1'b1;
        tick();
        checkpoint_req = 1'b0;
        resolve_valid = 1'b0;
        chk("t3_pp_count", dut.count_q, 4);
        chk("t3_pp_tail", dut.tail_q, 1);
        chk("t3_pp_head", dut.head_q, 1);
        chk("t3_pp_snap", regs_snapshot[0], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Capture concurrent with write-back of R7
        regs[7] = 32'h1;
        checkpoint_req = 1'b1;
        wb_if.uses_rw = 1'b1;
        wb_if.rw_addr = 5'd7;
        wb_if.rw_data = 32'hABCD;
        tick();
        checkpoint_req = 1'b0;
        wb_if.uses_rw = 1'b0;
        regs[7] = 32'hABCD;
        resolve_valid = 1'b1;
        resolve_mispredict = 1'b1;
        tick();
        resolve_valid = 1'b0;
        resolve_mispredict = 1'b0;
`ifdef SNAPSHOT_WB_BYPASS_EN
        exp_r7 = 32'hABCD;
`else
        exp_r7 = 32'h1;
`endif
        chk("t4_recover", recover_snapshot, 1);
        chk("t4_snap_r7", regs_snapshot[7], exp_r7);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk("t4_idle", recovering, 0);

        // Mispredict with empty queue is ignored
        resolve_valid = 1'b1;
        resolve_mispredict = 1'b1;
        tick();
        resolve_valid = 1'b0;
        resolve_mispredict = 1'b0;
        chk("t5_empty_idle", recovering, 0);
        chk("t5_empty_full", checkpoint_full, 0);
        checkpoint_req = 1'b1;
        tick();
        chk("t5_count1", dut.count_q, 1);
        resolve_valid = 1'b1;
        resolve_mispredict = 1'b1;
        tick();
        checkpoint_req = 1'b0;
        resolve_valid = 1'b0;
        resolve_mispredict = 1'b0;
        chk("t5_drop_tail", dut.tail_q, 1);
        chk("t5_drop_count", dut.count_q, 1);
        chk("t5_recovering", recovering, 1);
        // done during REQ must not advance past WAIT
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t5_req_done_ack", recovery_done_ack, 0);
        tick();
        chk("t5_wait_hold", recovering, 1);
        chk("t5_wait_ack", recovery_done_ack, 0);

        // Reset while in WAIT
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_idle", recovering, 0);
        chk("t6_rst_count", dut.count_q, 0);
        chk("t6_rst_full", checkpoint_full, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t6_done_ack", recovery_done_ack, 0);
        chk("t6_done_idle", recovering, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
